// File: rtl/theremin_sensor_pkg.sv
// Shared types and default widths for the theremin sensor datapath.
package theremin_sensor_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    STALE = 2'd2
  } window_state_t;

  localparam int unsigned PERIOD_IN_BITS     = 15;
  localparam int unsigned PERIOD_WINDOW_BITS = 4;

endpackage

// File: rtl/period_ring_buffer.sv
// D-entry circular store of period samples. OLDEST is the entry at the write
// pointer, i.e. the sample about to leave the window (zero while filling).
module period_ring_buffer
  import theremin_sensor_pkg::*;
#(
  parameter int unsigned IN_BITS     = PERIOD_IN_BITS,
  parameter int unsigned WINDOW_BITS = PERIOD_WINDOW_BITS
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CLEAR,
  input  logic               WRITE,
  input  logic [IN_BITS-1:0] WRITE_DATA,
  output logic [IN_BITS-1:0] OLDEST
);

  localparam int unsigned DEPTH = 1 << WINDOW_BITS;

  logic [IN_BITS-1:0]     entries [DEPTH];
  logic [WINDOW_BITS-1:0] wr_ptr;

  assign OLDEST = entries[wr_ptr];

  always_ff @(posedge CLK) begin
    if (!RESET || CLEAR) begin
      wr_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (WRITE) begin
      entries[wr_ptr] <= WRITE_DATA;
      wr_ptr          <= (wr_ptr == WINDOW_BITS'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/period_window_average.sv
// Sliding-window sum of the last 2^WINDOW_BITS period samples with idle
// timeout; the consumer divides OUT_SUM by the window depth.
module period_window_average
  import theremin_sensor_pkg::*;
#(
  parameter int unsigned IN_BITS      = PERIOD_IN_BITS,
  parameter int unsigned WINDOW_BITS  = PERIOD_WINDOW_BITS,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           IN_VALID,
  input  logic [IN_BITS-1:0]             IN_DURATION,
  output logic                           OUT_VALID,
  output logic [IN_BITS+WINDOW_BITS-1:0] OUT_SUM,
  output logic                           OUT_FULL,
  output logic                           OUT_TIMEOUT
);

  localparam int unsigned DEPTH = 1 << WINDOW_BITS;
  localparam int unsigned ACC_W = IN_BITS + WINDOW_BITS;
  localparam int unsigned CNT_W = WINDOW_BITS + 1;

  window_state_t             state;
  logic [ACC_W-1:0]          acc;
  logic [ACC_W-1:0]          acc_next;
  logic [CNT_W-1:0]          fill_cnt;
  logic [TIMEOUT_BITS-1:0]   idle_cnt;
  logic [TIMEOUT_BITS-1:0]   idle_inc;
  logic [IN_BITS-1:0]        oldest;
  logic                      accept;
  logic                      timeout_hit;

  // Timeout fires on the idle cycle whose increment would reach all-ones, so a
  // strobe in that same cycle wins and the window survives.
  always_comb begin
    accept      = IN_VALID && (state != STALE);
    idle_inc    = idle_cnt + 1'b1;
    timeout_hit = !IN_VALID && (state != STALE) && (&idle_inc) && !(&idle_cnt);
    acc_next    = acc + ACC_W'(IN_DURATION) - ACC_W'(oldest);
  end

  period_ring_buffer #(
    .IN_BITS     (IN_BITS),
    .WINDOW_BITS (WINDOW_BITS)
  ) u_ring (
    .CLK        (CLK),
    .RESET      (RESET),
    .CLEAR      (timeout_hit),
    .WRITE      (accept),
    .WRITE_DATA (IN_DURATION),
    .OLDEST     (oldest)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= STALE;
      acc         <= '0;
      fill_cnt    <= '0;
      idle_cnt    <= '0;
      OUT_VALID   <= 1'b0;
      OUT_SUM     <= '0;
      OUT_FULL    <= 1'b0;
      OUT_TIMEOUT <= 1'b1;
    end else begin
      OUT_VALID <= 1'b0;
      case (state)
        STALE: begin
          // The first strobe after a gap measures the gap itself; drop it.
          if (IN_VALID) begin
            state       <= FILL;
            idle_cnt    <= '0;
            OUT_TIMEOUT <= 1'b0;
          end
        end
        FILL, RUN: begin
          if (accept) begin
            acc      <= acc_next;
            idle_cnt <= '0;
            if (state == RUN) begin
              OUT_VALID <= 1'b1;
              OUT_SUM   <= acc_next;
            end else if (fill_cnt == CNT_W'(DEPTH - 1)) begin
              state     <= RUN;
              fill_cnt  <= CNT_W'(DEPTH);
              OUT_VALID <= 1'b1;
              OUT_SUM   <= acc_next;
              OUT_FULL  <= 1'b1;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end else if (timeout_hit) begin
            state       <= STALE;
            acc         <= '0;
            fill_cnt    <= '0;
            idle_cnt    <= '1;
            OUT_FULL    <= 1'b0;
            OUT_TIMEOUT <= 1'b1;
          end else begin
            idle_cnt <= idle_inc;
          end
        end
        default: state <= STALE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_window_average.sv
// Bench for period_window_average with D=4, 15-bit samples, 15-cycle timeout.
module tb_period_window_average;

  localparam int unsigned IB = 15;
  localparam int unsigned WB = 2;
  localparam int unsigned TB = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned IDLE_LIMIT = 15;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              IN_VALID = 1'b0;
  logic [IB-1:0]     IN_DURATION = '0;
  logic              OUT_VALID;
  logic [IB+WB-1:0]  OUT_SUM;
  logic              OUT_FULL;
  logic              OUT_TIMEOUT;

  int checks = 0;
  int failures = 0;

  period_window_average #(
    .IN_BITS      (IB),
    .WINDOW_BITS  (WB),
    .TIMEOUT_BITS (TB)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN_VALID    (IN_VALID),
    .IN_DURATION (IN_DURATION),
    .OUT_VALID   (OUT_VALID),
    .OUT_SUM     (OUT_SUM),
    .OUT_FULL    (OUT_FULL),
    .OUT_TIMEOUT (OUT_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // Reference model: window contents as a queue, sum recomputed from scratch.
  int  window[$];
  bit  m_stale;
  int  m_idle;
  int  e_valid, e_sum, e_full, e_timeout;

  function automatic int window_sum();
    int s = 0;
    foreach (window[i]) s += window[i];
    return s;
  endfunction

  task automatic model_edge(input bit rst_n, input bit v, input int d);
    if (!rst_n) begin
      window.delete();
      m_stale = 1; m_idle = 0;
      e_valid = 0; e_sum = 0; e_full = 0; e_timeout = 1;
    end else begin
      e_valid = 0;
      if (m_stale) begin
        if (v) begin m_stale = 0; m_idle = 0; e_timeout = 0; end
      end else if (v) begin
        window.push_back(d);
        if (window.size() > D) void'(window.pop_front());
        m_idle = 0;
        if (window.size() == D) begin e_valid = 1; e_sum = window_sum(); e_full = 1; end
      end else begin
        m_idle++;
        if (m_idle == IDLE_LIMIT) begin
          m_stale = 1; window.delete(); e_full = 0; e_timeout = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, clock edge, advance model, sample #1 later.
  task automatic tick(input bit v, input int d);
    IN_VALID = v;
    IN_DURATION = IB'(d);
    @(posedge CLK);
    model_edge(RESET, v, d);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},   int'(OUT_VALID),   e_valid);
    chk({tag, ".sum"},     int'(OUT_SUM),     e_sum);
    chk({tag, ".full"},    int'(OUT_FULL),    e_full);
    chk({tag, ".timeout"}, int'(OUT_TIMEOUT), e_timeout);
  endtask

  task automatic check_out(input string tag, input int v, input int s, input int f, input int t);
    chk({tag, ".valid"},   int'(OUT_VALID),   v);
    chk({tag, ".sum"},     int'(OUT_SUM),     s);
    chk({tag, ".full"},    int'(OUT_FULL),    f);
    chk({tag, ".timeout"}, int'(OUT_TIMEOUT), t);
  endtask

  task automatic do_reset(input int cycles);
    RESET = 1'b0;
    for (int i = 0; i < cycles; i++) tick(0, 0);
    RESET = 1'b1;
  endtask

  typedef struct {
    bit v;
    int d;
    int ev;
    int es;
    int ef;
    int et;
  } vec_t;

  function automatic vec_t mk(bit v, int d, int ev, int es, int ef, int et);
    vec_t r;
    r.v = v; r.d = d; r.ev = ev; r.es = es; r.ef = ef; r.et = et;
    return r;
  endfunction

  vec_t tbl[23];

  initial begin
    // Fill with 3-cycle spacing, slide/wrap, then full-rate max values.
    tbl[0]  = mk(1, 999,   0, 0,      0, 0);
    tbl[1]  = mk(0, 0,     0, 0,      0, 0);
    tbl[2]  = mk(0, 0,     0, 0,      0, 0);
    tbl[3]  = mk(1, 100,   0, 0,      0, 0);
    tbl[4]  = mk(0, 0,     0, 0,      0, 0);
    tbl[5]  = mk(0, 0,     0, 0,      0, 0);
    tbl[6]  = mk(1, 200,   0, 0,      0, 0);
    tbl[7]  = mk(0, 0,     0, 0,      0, 0);
    tbl[8]  = mk(0, 0,     0, 0,      0, 0);
    tbl[9]  = mk(1, 300,   0, 0,      0, 0);
    tbl[10] = mk(0, 0,     0, 0,      0, 0);
    tbl[11] = mk(0, 0,     0, 0,      0, 0);
    tbl[12] = mk(1, 400,   1, 1000,   1, 0);
    tbl[13] = mk(0, 0,     0, 1000,   1, 0);
    tbl[14] = mk(1, 500,   1, 1400,   1, 0);
    tbl[15] = mk(1, 600,   1, 1800,   1, 0);
    tbl[16] = mk(0, 0,     0, 1800,   1, 0);
    tbl[17] = mk(1, 32767, 1, 34267,  1, 0);
    tbl[18] = mk(1, 32767, 1, 66634,  1, 0);
    tbl[19] = mk(1, 32767, 1, 98901,  1, 0);
    tbl[20] = mk(1, 32767, 1, 131068, 1, 0);
    tbl[21] = mk(1, 32767, 1, 131068, 1, 0);
    tbl[22] = mk(1, 32767, 1, 131068, 1, 0);

    // Reset
    do_reset(3);
    check_out("reset", 0, 0, 0, 1);

    // Table vectors
    foreach (tbl[i]) begin
      tick(tbl[i].v, tbl[i].d);
      check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ef, tbl[i].et);
    end

    // Timeout after 15 idle cycles, sum holds
    for (int i = 0; i < 14; i++) tick(0, 0);
    check_out("idle14", 0, 131068, 1, 0);
    tick(0, 0);
    check_out("idle15", 0, 131068, 0, 1);

    // Coincidence: strobe on the 15th idle cycle keeps the window
    tick(1, 77);
    check_out("discard", 0, 131068, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, 1);
    check_out("fill_ones", 1, 4, 1, 0);
    for (int i = 0; i < 14; i++) tick(0, 0);
    tick(1, 5);
    check_out("coincide", 1, 8, 1, 0);
    for (int i = 0; i < 15; i++) tick(0, 0);
    check_out("coincide_to", 0, 8, 0, 1);

    // Reset mid-fill clears buffer contents
    tick(1, 3);
    tick(1, 7);
    tick(1, 9);
    check_out("midfill", 0, 8, 0, 0);
    do_reset(1);
    check_out("midreset", 0, 0, 0, 1);
    tick(1, 123);
    for (int i = 0; i < 3; i++) tick(1, 10);
    check_out("refill3", 0, 0, 0, 0);
    tick(1, 10);
    check_out("refill4", 1, 40, 1, 0);

    // Randomized traffic against the model, including idle bursts near the limit
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
        check_model("rnd_rst");
      end else if ($urandom_range(0, 29) == 0) begin
        int n = $urandom_range(12, 17);
        for (int k = 0; k < n; k++) begin
          tick(0, 0);
          check_model("rnd_idle");
        end
      end else begin
        bit v = ($urandom_range(0, 2) != 0);
        int d = (($urandom_range(0, 7) == 0) ? 32767 : int'($urandom_range(0, 32767)));
        tick(v, d);
        check_model("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
